inst_cache_mem: RTL and testbench

//  Instruction store for the fetch path: a block-wide memory array plus a direct-mapped

---
 rtl/inst_cache_mem.sv | 143 ++++++++++++++
 tb/tb_inst_cache_mem.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/inst_cache_mem.sv
// Instruction store: block-wide memory array with registered dual-block reads, fronted by a
// direct-mapped block cache that refills from the array.
module inst_cache_mem #(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned BLOCK_SIZE  = 1024,
  parameter int unsigned MEM_BLOCKS  = 16,
  parameter int unsigned CACHE_LINES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_SIZE-1:0]  in,
  input  logic                  readable,
  input  logic                  writable,
  input  logic [BLOCK_SIZE-1:0] write,
  output logic [BLOCK_SIZE-1:0] out1,
  output logic [BLOCK_SIZE-1:0] out2,
  output logic [BLOCK_SIZE-1:0] out,
  output logic                  out_valid,
  output logic                  hit
);

  localparam int unsigned ABITS = $clog2(MEM_BLOCKS);
  localparam int unsigned IBITS = $clog2(CACHE_LINES);
  localparam int unsigned TBITS = ABITS - IBITS;

  typedef enum logic {IDLE, FILL} state_t;

  state_t state, state_nx;

  logic [BLOCK_SIZE-1:0] mem       [MEM_BLOCKS];
  logic [BLOCK_SIZE-1:0] line_data [CACHE_LINES];
  logic [TBITS-1:0]      line_tag  [CACHE_LINES];
  logic [CACHE_LINES-1:0] line_valid;

  logic [ABITS-1:0] a, a_nx, lat_a;
  logic [IBITS-1:0] idx, lat_idx;
  logic [TBITS-1:0] tag, lat_tag;
  logic             resident_c;
  logic             fill_en_c;
  logic             latch_en_c;
  logic [BLOCK_SIZE-1:0] fill_data_c;
  logic [BLOCK_SIZE-1:0] out_d;
  logic             out_valid_d;
  logic             hit_d;
  logic             unused_in;

  // Address decode: block index taken modulo the array depth
  assign a          = in[ABITS-1:0];
  assign a_nx       = ABITS'(a + ABITS'(1));
  assign idx        = a[IBITS-1:0];
  assign tag        = a[ABITS-1:IBITS];
  assign lat_idx    = lat_a[IBITS-1:0];
  assign lat_tag    = lat_a[ABITS-1:IBITS];
  assign unused_in  = ^in[WORD_SIZE-1:ABITS];
  assign resident_c = line_valid[idx] && (line_tag[idx] == tag);

  // A refill of the block being written this cycle must see the new data
  assign fill_data_c = (writable && (a == lat_a)) ? write : mem[lat_a];

  // Array write port; contents survive reset
  always_ff @(posedge clk) begin
    if (writable) mem[a] <= write;
  end

  // Registered dual-block read, old data on read/write collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out1 <= '0;
      out2 <= '0;
    end else if (readable) begin
      out1 <= mem[a];
      out2 <= mem[a_nx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!resident_c) state_nx = FILL;
      FILL:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    out_d       = out;
    out_valid_d = out_valid;
    hit_d       = hit;
    fill_en_c   = 1'b0;
    latch_en_c  = 1'b0;
    case (state)
      IDLE: begin
        if (resident_c) begin
          out_d       = line_data[idx];
          out_valid_d = 1'b1;
          hit_d       = 1'b1;
        end else begin
          out_valid_d = 1'b0;
          hit_d       = 1'b0;
          latch_en_c  = 1'b1;
        end
      end
      FILL: begin
        fill_en_c   = 1'b1;
        out_d       = fill_data_c;
        out_valid_d = 1'b1;
        hit_d       = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out        <= '0;
      out_valid  <= 1'b0;
      hit        <= 1'b0;
      lat_a      <= '0;
      line_valid <= '0;
    end else begin
      out       <= out_d;
      out_valid <= out_valid_d;
      hit       <= hit_d;
      if (latch_en_c) lat_a <= a;
      if (fill_en_c)  line_valid[lat_idx] <= 1'b1;
    end
  end

  // Line payload; a refill overrides a coherence update to the same line
  always_ff @(posedge clk) begin
    if (writable && resident_c) line_data[idx] <= write;
    if (fill_en_c) begin
      line_data[lat_idx] <= fill_data_c;
      line_tag[lat_idx]  <= lat_tag;
    end
  end

endmodule

// File: tb/tb_inst_cache_mem.sv
// Directed bench for inst_cache_mem: memory port reads/writes, wrap, cache miss/hit/coherence, reset.
module tb_inst_cache_mem;

  localparam int unsigned WS = 32;
  localparam int unsigned BS = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic [WS-1:0] in;
  logic          readable;
  logic          writable;
  logic [BS-1:0] write;
  logic [BS-1:0] out1, out2, out;
  logic          out_valid, hit;

  int checks = 0;
  int errors = 0;

  inst_cache_mem dut (
    .clk(clk), .rst(rst), .in(in), .readable(readable), .writable(writable),
    .write(write), .out1(out1), .out2(out2), .out(out), .out_valid(out_valid), .hit(hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BS-1:0] got, input logic [BS-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (low 64 bits)", tag, got[63:0], exp[63:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int data);
    writable = 1'b1;
    in       = WS'(addr);
    write    = BS'(data);
    step();
    writable = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in = '0; readable = 1'b0; writable = 1'b0; write = '0;
    step(); step();
    check("rst_out1", out1, '0);
    check("rst_out2", out2, '0);
    check("rst_out", out, '0);
    check("rst_valid", BS'(out_valid), '0);
    check("rst_hit", BS'(hit), '0);
    rst = 1'b0;

    // write then dual read of block 0
    wr(0, 30);
    readable = 1'b1; in = '0; step(); readable = 1'b0;
    check("rd0_out1", out1, BS'(30));
    check("rd0_out2", out2, '0);

    // wrap from block 15 to block 0
    wr(15, 5);
    wr(0, 7);
    readable = 1'b1; in = WS'(15); step(); readable = 1'b0;
    check("wrap_out1", out1, BS'(5));
    check("wrap_out2", out2, BS'(7));

    // park on block 0 so the cache sits in IDLE with it resident
    in = '0; step(); step(); step();
    check("park_hit", BS'(hit), BS'(1));

    // mem[1]=9 pulls block 1 into line 1, then block 5 evicts it
    wr(1, 9);
    in = WS'(5); step(); step(); step();
    in = WS'(1); step();
    check("miss1_valid", BS'(out_valid), '0);
    check("miss1_hit", BS'(hit), '0);
    step();
    check("fill1_out", out, BS'(9));
    check("fill1_valid", BS'(out_valid), BS'(1));
    check("fill1_hit", BS'(hit), '0);
    step();
    check("hit1_out", out, BS'(9));
    check("hit1_hit", BS'(hit), BS'(1));

    // conflicting index: 5 then 1 both miss
    in = WS'(5); step();
    check("miss5_valid", BS'(out_valid), '0);
    step();
    check("fill5_out", out, '0);
    check("fill5_hit", BS'(hit), '0);
    in = WS'(1); step();
    check("remiss1_valid", BS'(out_valid), '0);
    step();
    check("refill1_out", out, BS'(9));
    check("refill1_hit", BS'(hit), '0);

    // coherence: write to resident block returns old data that cycle, new data after
    writable = 1'b1; write = BS'(3); in = WS'(1); step(); writable = 1'b0;
    check("coh_same_out", out, BS'(9));
    check("coh_same_hit", BS'(hit), BS'(1));
    step();
    check("coh_new_out", out, BS'(3));
    check("coh_new_hit", BS'(hit), BS'(1));

    // refill of the block written in the same cycle loads the write data
    in = WS'(6); step();
    check("miss6_valid", BS'(out_valid), '0);
    writable = 1'b1; write = BS'(11); step(); writable = 1'b0;
    check("fillwr_out", out, BS'(11));
    check("fillwr_hit", BS'(hit), '0);
    step();
    check("hit6_out", out, BS'(11));
    check("hit6_hit", BS'(hit), BS'(1));

    // read/write collision returns old data, next read returns new
    wr(2, 4);
    readable = 1'b1; writable = 1'b1; in = WS'(2); write = BS'(8); step();
    writable = 1'b0;
    check("coll_out1", out1, BS'(4));
    check("coll_out2", out2, '0);
    step();
    check("coll_new_out1", out1, BS'(8));

    // readable low holds the read registers
    readable = 1'b0; in = WS'(15); step();
    check("hold_out1", out1, BS'(8));
    check("hold_out2", out2, '0);

    // reset during FILL aborts the refill
    in = WS'(9); step();
    rst = 1'b1; #2;
    check("midrst_valid", BS'(out_valid), '0);
    check("midrst_out", out, '0);
    check("midrst_out1", out1, '0);
    rst = 1'b0;
    step();
    check("postrst_miss", BS'(out_valid), '0);
    step();
    check("postrst_fill", out, '0);
    check("postrst_fill_valid", BS'(out_valid), BS'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
